// File: rtl/id_ex_debug_reader.sv
// id_ex_debug_reader
//
// Debug-side reader for the ID/EX pipeline register. It takes single-byte
// commands from the debug UART receiver. A step command pulses the pipeline
// step enable for one clock. A step or read command then snapshots the ID/EX
// outputs and streams the snapshot to the debug UART transmitter as a
// fixed-length byte frame over a valid/ready handshake.
//
// Ports
//   i_clk, i_reset              clock (rising edge); synchronous active-high reset
//   i_rx_data, i_rx_valid       command byte and its one-cycle strobe
//   o_step                      pipeline step enable, one cycle per step command
//   i_instruction_funct_code,
//   i_instruction_op_code,
//   i_alu_src, i_branch,
//   i_word_size, i_data_a,
//   i_data_b, i_extension_result  ID/EX outputs to snapshot
//   o_tx_data, o_tx_valid,
//   i_tx_ready                  byte stream to the UART transmitter
//   o_busy                      high whenever a command is in progress
//
// Frame layout, sent in this order:
//   data_a (MSB byte first), data_b (MSB byte first),
//   extension_result (MSB byte first), {op_code, alu_src, branch},
//   {funct_code, 2'b00}, {5'b0, word_size}
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting for a command byte; all other bytes are ignored
// ST_STEP    | o_step high; ID/EX updates on the falling edge of this cycle
// ST_CAPTURE | latch the ID/EX outputs into the snapshot, clear the byte index
// ST_SEND    | present frame[byte index]; advance on each handshake

module id_ex_debug_reader #(
  parameter int         NB        = 32,
  parameter int         NB_OPCODE = 6,
  parameter int         NB_FCODE  = 6,
  parameter logic [7:0] CMD_STEP  = 8'h53,
  parameter logic [7:0] CMD_READ  = 8'h52
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_valid,
  output logic                 o_step,
  input  logic [NB_FCODE-1:0]  i_instruction_funct_code,
  input  logic [NB_OPCODE-1:0] i_instruction_op_code,
  input  logic                 i_alu_src,
  input  logic                 i_branch,
  input  logic [2:0]           i_word_size,
  input  logic [NB-1:0]        i_data_a,
  input  logic [NB-1:0]        i_data_b,
  input  logic [NB-1:0]        i_extension_result,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_valid,
  input  logic                 i_tx_ready,
  output logic                 o_busy
);

  localparam int NBYTES    = NB / 8;
  localparam int FRAME_LEN = 3 * NBYTES + 3;
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STEP,
    ST_CAPTURE,
    ST_SEND
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]     byte_cnt;
  logic [NB_FCODE-1:0]  snap_fcode;
  logic [NB_OPCODE-1:0] snap_opcode;
  logic                 snap_alu_src;
  logic                 snap_branch;
  logic [2:0]           snap_word_size;
  logic [NB-1:0]        snap_data_a;
  logic [NB-1:0]        snap_data_b;
  logic [NB-1:0]        snap_ext;

  logic [7:0] frame [FRAME_LEN];
  logic       tx_fire;

  assign tx_fire = o_tx_valid && i_tx_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= ST_IDLE;
      byte_cnt       <= '0;
      snap_fcode     <= '0;
      snap_opcode    <= '0;
      snap_alu_src   <= 1'b0;
      snap_branch    <= 1'b0;
      snap_word_size <= '0;
      snap_data_a    <= '0;
      snap_data_b    <= '0;
      snap_ext       <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CAPTURE) begin
        snap_fcode     <= i_instruction_funct_code;
        snap_opcode    <= i_instruction_op_code;
        snap_alu_src   <= i_alu_src;
        snap_branch    <= i_branch;
        snap_word_size <= i_word_size;
        snap_data_a    <= i_data_a;
        snap_data_b    <= i_data_b;
        snap_ext       <= i_extension_result;
        byte_cnt       <= '0;
      end else if (tx_fire && byte_cnt != LAST_IDX) begin
        // Hold on the last byte so the index never leaves the frame.
        byte_cnt <= byte_cnt + 1'b1;
      end
    end
  end

  // Frame bytes; narrow fields are zero-extended on the MSB side.
  always_comb begin
    for (int k = 0; k < FRAME_LEN; k++) begin
      frame[k] = '0;
    end
    for (int i = 0; i < NBYTES; i++) begin
      frame[i]            = snap_data_a[NB-1-8*i -: 8];
      frame[NBYTES+i]     = snap_data_b[NB-1-8*i -: 8];
      frame[2*NBYTES+i]   = snap_ext[NB-1-8*i -: 8];
    end
    frame[3*NBYTES]   = 8'({snap_opcode, snap_alu_src, snap_branch});
    frame[3*NBYTES+1] = 8'({snap_fcode, 2'b00});
    frame[3*NBYTES+2] = {5'b0, snap_word_size};
  end

  always_comb begin
    state_nxt  = state;
    o_step     = 1'b0;
    o_tx_valid = 1'b0;
    o_tx_data  = '0;
    o_busy     = (state != ST_IDLE);
    unique case (state)
      ST_IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == CMD_STEP) begin
            state_nxt = ST_STEP;
          end else if (i_rx_data == CMD_READ) begin
            state_nxt = ST_CAPTURE;
          end
        end
      end
      ST_STEP: begin
        o_step    = 1'b1;
        state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_nxt = ST_SEND;
      end
      ST_SEND: begin
        o_tx_valid = 1'b1;
        o_tx_data  = frame[byte_cnt];
        if (tx_fire && byte_cnt == LAST_IDX) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_id_ex_debug_reader.sv
module tb_id_ex_debug_reader;

  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_READ = 8'h52;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ext;
    logic [5:0]  op;
    logic        alu;
    logic        br;
    logic [5:0]  fn;
    logic [2:0]  ws;
  } pipe_t;

  logic       clk = 1'b0;
  logic       i_reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       o_step;
  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic       tx_ready;
  logic       o_busy;

  pipe_t pipe, nxt;
  logic  load_now, scramble;

  int n_checks = 0;
  int n_errors = 0;
  int step_cnt = 0;
  int step_run = 0;
  int last_run = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  id_ex_debug_reader dut (
    .i_clk                    (clk),
    .i_reset                  (i_reset),
    .i_rx_data                (rx_data),
    .i_rx_valid               (rx_valid),
    .o_step                   (o_step),
    .i_instruction_funct_code (pipe.fn),
    .i_instruction_op_code    (pipe.op),
    .i_alu_src                (pipe.alu),
    .i_branch                 (pipe.br),
    .i_word_size              (pipe.ws),
    .i_data_a                 (pipe.a),
    .i_data_b                 (pipe.b),
    .i_extension_result       (pipe.ext),
    .o_tx_data                (o_tx_data),
    .o_tx_valid               (o_tx_valid),
    .i_tx_ready               (tx_ready),
    .o_busy                   (o_busy)
  );

  function automatic pipe_t rand_pipe();
    pipe_t p;
    p.a   = $urandom;
    p.b   = $urandom;
    p.ext = $urandom;
    p.op  = 6'($urandom);
    p.alu = 1'($urandom);
    p.br  = 1'($urandom);
    p.fn  = 6'($urandom);
    p.ws  = 3'($urandom);
    return p;
  endfunction

  // Pipeline model: ID/EX updates on the falling edge while step is high.
  always @(negedge clk) begin
    if (o_step) begin
      step_run <= step_run + 1;
      if (step_run == 0) step_cnt <= step_cnt + 1;
    end else begin
      if (step_run != 0) last_run <= step_run;
      step_run <= 0;
    end
    if (o_step || load_now) pipe <= nxt;
    else if (scramble)      pipe <= rand_pipe();
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic build_exp(input pipe_t p);
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(8'(p.a >> (24 - 8*k)));
    for (int k = 0; k < 4; k++) exp_q.push_back(8'(p.b >> (24 - 8*k)));
    for (int k = 0; k < 4; k++) exp_q.push_back(8'(p.ext >> (24 - 8*k)));
    exp_q.push_back(8'(int'(p.op) * 4 + int'(p.alu) * 2 + int'(p.br)));
    exp_q.push_back(8'(int'(p.fn) * 4));
    exp_q.push_back(8'(int'(p.ws)));
  endtask

  task automatic set_pipe(input pipe_t p);
    nxt = p;
    load_now = 1'b1;
    repeat (2) @(negedge clk);
    load_now = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Receives bytes until the frame completes or abort_at bytes are taken.
  task automatic collect(input int stall_at, input int stall_len, input int inject_at,
                         input int abort_at, input bit scr);
    int idx = 0;
    int stall = 0;
    int budget = 300;
    bit injected = 0;
    got_q.delete();
    while (idx < 15 && budget > 0) begin
      @(negedge clk);
      budget--;
      rx_valid = 1'b0;
      if (scr && o_tx_valid) scramble = 1'b1;
      if (idx == inject_at && o_tx_valid && !injected) begin
        rx_data  = CMD_STEP;
        rx_valid = 1'b1;
        injected = 1;
      end
      if (idx == stall_at && idx > 0 && stall < stall_len) begin
        tx_ready = 1'b0;
        stall++;
        check_val("stall_valid", 32'(o_tx_valid), 32'd1);
        check_val("stall_data", 32'(o_tx_data), 32'(exp_q[idx]));
      end else begin
        tx_ready = 1'b1;
      end
      if (o_tx_valid && tx_ready) begin
        got_q.push_back(o_tx_data);
        idx++;
      end
      if (abort_at > 0 && idx == abort_at) break;
    end
    scramble = 1'b0;
    check_val("frame_progress", 32'(idx), 32'((abort_at > 0) ? abort_at : 15));
  endtask

  task automatic compare_frame(input string tag);
    check_val({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check_val($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    @(negedge clk);
    check_val({tag, "_end_busy"}, 32'(o_busy), 32'd0);
    check_val({tag, "_end_valid"}, 32'(o_tx_valid), 32'd0);
  endtask

  initial begin
    pipe_t p;
    int s0, seen;
    i_reset  = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    load_now = 1'b0;
    scramble = 1'b0;
    nxt      = '0;
    pipe     = '0;
    repeat (3) @(negedge clk);
    check_val("rst_step", 32'(o_step), 32'd0);
    check_val("rst_valid", 32'(o_tx_valid), 32'd0);
    check_val("rst_data", 32'(o_tx_data), 32'd0);
    check_val("rst_busy", 32'(o_busy), 32'd0);
    i_reset  = 1'b0;
    tx_ready = 1'b1;

    // Directed read with known fields.
    p = '{a: 32'h11223344, b: 32'hAABBCCDD, ext: 32'hFFFF8000, op: 6'h23,
          alu: 1'b1, br: 1'b0, fn: 6'h21, ws: 3'b100};
    set_pipe(p);
    build_exp(p);
    s0 = step_cnt;
    send_cmd(CMD_READ);
    check_val("read_lat_valid", 32'(o_tx_valid), 32'd0);
    check_val("read_lat_busy", 32'(o_busy), 32'd1);
    collect(-1, 0, -1, 0, 0);
    compare_frame("read");
    check_val("read_no_step", 32'(step_cnt - s0), 32'd0);

    // Step: frame must carry the post-step values.
    set_pipe(rand_pipe());
    nxt = rand_pipe();
    build_exp(nxt);
    s0 = step_cnt;
    send_cmd(CMD_STEP);
    check_val("step_lat_step", 32'(o_step), 32'd1);
    check_val("step_lat_valid", 32'(o_tx_valid), 32'd0);
    collect(-1, 0, -1, 0, 0);
    compare_frame("step");
    check_val("step_pulses", 32'(step_cnt - s0), 32'd1);
    check_val("step_width", 32'(last_run), 32'd1);

    // Back-pressure on byte 3.
    build_exp(pipe);
    send_cmd(CMD_READ);
    collect(3, 5, -1, 0, 0);
    compare_frame("stall");

    // Command during SEND, then a stray byte in IDLE.
    build_exp(pipe);
    s0 = step_cnt;
    send_cmd(CMD_READ);
    collect(-1, 0, 5, 0, 0);
    compare_frame("inject");
    send_cmd(8'h41);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_busy || o_tx_valid) seen++;
    end
    check_val("ignored_busy", 32'(seen), 32'd0);
    check_val("ignored_steps", 32'(step_cnt - s0), 32'd0);

    // Reset after six bytes, then a clean restart.
    build_exp(pipe);
    send_cmd(CMD_READ);
    collect(-1, 0, -1, 6, 0);
    @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    check_val("abort_valid", 32'(o_tx_valid), 32'd0);
    check_val("abort_busy", 32'(o_busy), 32'd0);
    i_reset = 1'b0;
    send_cmd(CMD_READ);
    collect(-1, 0, -1, 0, 0);
    compare_frame("restart");

    // Inputs change every cycle during SEND.
    p = rand_pipe();
    set_pipe(p);
    build_exp(p);
    send_cmd(CMD_READ);
    collect(-1, 0, -1, 0, 1);
    compare_frame("frozen");

    // Randomized rounds.
    for (int r = 0; r < 4; r++) begin
      bit do_step;
      do_step = 1'($urandom);
      set_pipe(rand_pipe());
      if (do_step) begin
        nxt = rand_pipe();
        build_exp(nxt);
        send_cmd(CMD_STEP);
      end else begin
        build_exp(pipe);
        send_cmd(CMD_READ);
      end
      collect(int'($urandom_range(1, 14)), int'($urandom_range(0, 4)), -1, 0, 1'($urandom));
      compare_frame($sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/id_ex_debug_reader.md
Name: id_ex_debug_reader

Overview:
- Debug-side reader for the ID/EX pipeline register. It receives single-byte commands from the debug UART receiver.
- On a step command it pulses the pipeline step enable for exactly one clock, captures the ID/EX outputs once they have settled, and streams the snapshot as a fixed-length byte frame to the debug UART transmitter over a valid/ready handshake.
- It sits between the UART RX/TX pair and the pipeline's step and ID/EX output buses.

Parameters:
- NB, 32, data width of the data_a, data_b and extension_result fields; must be a multiple of 8.
- NB_OPCODE, 6, opcode field width.
- NB_FCODE, 6, funct code field width.
- CMD_STEP, 8'h53, command byte that steps the pipeline, then reads it.
- CMD_READ, 8'h52, command byte that reads the pipeline without stepping.

Ports:
- i_clk  in  1  single clock; this block acts on rising edges.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_data  in  8  command byte from the UART receiver.
- i_rx_valid  in  1  one-cycle strobe marking i_rx_data as valid.
- o_step  out  1  pipeline step enable; high for exactly one cycle per CMD_STEP.
- i_instruction_funct_code  in  NB_FCODE  ID/EX funct code output.
- i_instruction_op_code  in  NB_OPCODE  ID/EX opcode output.
- i_alu_src  in  1  ID/EX ALU source select output.
- i_branch  in  1  ID/EX branch flag output.
- i_word_size  in  3  ID/EX word size output.
- i_data_a  in  NB  ID/EX operand A output.
- i_data_b  in  NB  ID/EX operand B output.
- i_extension_result  in  NB  ID/EX sign-extended immediate output.
- o_tx_data  out  8  frame byte presented to the UART transmitter.
- o_tx_valid  out  1  o_tx_data is valid.
- i_tx_ready  in  1  transmitter accepts the byte on a rising edge where valid and ready are both high.
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: o_step=0, o_tx_valid=0, o_tx_data=0, o_busy=0, snapshot registers=0, byte counter=0, state=IDLE. Reset is synchronous and dominates all other inputs.
- Reset mid-operation: abort the command, drop the rest of the frame, clear o_tx_valid in the same edge. No partial resume.
- States:
  - IDLE:
    - i_rx_valid with data==CMD_STEP -> STEP.
    - i_rx_valid with data==CMD_READ -> CAPTURE.
    - Any other byte is ignored; stay in IDLE.
  - STEP: o_step=1 for this one cycle only. The ID/EX register updates on the falling edge inside this cycle. -> CAPTURE.
  - CAPTURE: latch all i_* pipeline fields into the snapshot registers; clear the byte counter. -> SEND.
  - SEND:
    - o_tx_valid=1; o_tx_data=frame[counter].
    - o_tx_data and o_tx_valid stay stable until the handshake completes.
    - On handshake: counter+1. If the last byte was just accepted -> IDLE with o_tx_valid=0 on that same edge.
- Latency: CMD_STEP strobe at edge N gives o_step high N+1..N+2 and the capture at edge N+2. The first byte is valid from edge N+3 (CMD_READ: one cycle earlier, with no o_step).
- Frame order, FRAME_LEN = 3*NB/8 + 3 bytes (15 bytes for NB=32):
  - data_a, MSB byte first.
  - data_b, MSB byte first.
  - extension_result, MSB byte first.
  - {op_code, alu_src, branch}.
  - {funct_code, 2'b00}.
  - {5'b0, word_size}.
- Narrow fields are zero-extended on the MSB side where NB_OPCODE or NB_FCODE differ from 6.
- Commands received while o_busy=1 are dropped: no queueing and no effect on the frame in progress.
- The snapshot is frozen after CAPTURE; changes on the pipeline inputs during SEND do not alter the frame.
- i_tx_ready asserted while o_tx_valid=0 has no effect.
- The byte counter never wraps past FRAME_LEN-1.
- o_step never asserts outside STEP; back-to-back CMD_STEP commands produce one pulse per completed frame.

Test Plan:
1. Reset, then CMD_READ with data_a=32'h11223344, data_b=32'hAABBCCDD, ext=32'hFFFF8000, op=6'h23, alu_src=1, branch=0, funct=6'h21, word_size=3'b100, i_tx_ready=1 constant:
   - 15 consecutive bytes 11 22 33 44 AA BB CC DD FF FF 80 00 8E 84 04.
   - o_step stays 0.
2. CMD_STEP, with the pipeline model updating on the falling edge while o_step=1:
   - o_step is high for exactly 1 cycle.
   - The frame carries the post-step values, not the pre-step values.
3. i_tx_ready held low for 5 cycles on byte 3, then high:
   - o_tx_data stays at byte 3 and o_tx_valid stays 1 throughout.
   - No byte is skipped or duplicated.
4. CMD_STEP sent again during SEND, then byte 8'h41 sent in IDLE:
   - Both are ignored: no second o_step and no second frame.
   - o_busy falls after byte 15.
5. i_reset pulsed after byte 6 is accepted:
   - Next edge: o_tx_valid=0, o_busy=0.
   - A following CMD_READ restarts the frame from byte 0.
6. The pipeline inputs change every cycle during SEND:
   - The transmitted bytes match the values present at CAPTURE.
